// File: rtl/stoch_argmax_sched.sv
// stoch_argmax_sched: sequential champion/challenger argmax over signed stochastic bitstreams
module stoch_argmax_sched #(
  parameter int N_IN = 4,
  parameter int WINDOW = 16,
  parameter int CNT_W = 8,
  localparam int IDX_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [N_IN-1:0]  a_p,
  input  logic [N_IN-1:0]  a_m,
  output logic             busy,
  output logic             done,
  output logic             winner_valid,
  output logic [IDX_W-1:0] winner_idx,
  output logic             y_p,
  output logic             y_m
);
  localparam int CW = $clog2(WINDOW + 1);
  typedef enum logic [1:0] {IDLE, RUN, DECIDE, DONE} state_t;
  state_t                   r_state, w_next;
  logic [IDX_W-1:0]         r_champ, r_chal;
  logic signed [CNT_W-1:0]  r_acc;
  logic [CW-1:0]            r_cnt;
  logic                     r_valid;
  logic signed [1:0]        w_vh, w_vc;
  logic signed [2:0]        w_delta;
  logic signed [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]         w_sat;
  logic                     w_last;
  // p^m is the magnitude bit; m&~p marks the negative value
  assign w_vh    = {a_m[r_champ] & ~a_p[r_champ], a_p[r_champ] ^ a_m[r_champ]};
  assign w_vc    = {a_m[r_chal] & ~a_p[r_chal], a_p[r_chal] ^ a_m[r_chal]};
  assign w_delta = 3'(w_vc) - 3'(w_vh);
  assign w_sum   = (CNT_W+1)'(r_acc) + (CNT_W+1)'(w_delta);
  assign w_sat   = (w_sum[CNT_W] ^ w_sum[CNT_W-1]) ? {w_sum[CNT_W], {(CNT_W-1){~w_sum[CNT_W]}}}
                                                   : w_sum[CNT_W-1:0];
  assign w_last  = r_chal == IDX_W'(N_IN - 1);
  assign busy         = (r_state == RUN) || (r_state == DECIDE);
  assign done         = r_state == DONE;
  assign winner_valid = r_valid;
  assign winner_idx   = r_champ;
  assign y_p          = a_p[r_champ];
  assign y_m          = a_m[r_champ];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = (r_cnt == CW'(WINDOW - 1)) ? DECIDE : RUN;
      DECIDE:  w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_champ <= '0;
      r_chal  <= IDX_W'(1);
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_champ <= '0;
          r_chal  <= IDX_W'(1);
          r_acc   <= '0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
        RUN: begin
          r_acc <= w_sat;
          r_cnt <= r_cnt + CW'(1);
        end
        DECIDE: begin
          if (r_acc > 0) r_champ <= r_chal;
          r_acc <= '0;
          r_cnt <= '0;
          if (w_last) r_valid <= 1'b1;
          else r_chal <= r_chal + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stoch_argmax_sched.sv
// tb_stoch_argmax_sched: directed scoreboard bench for the stochastic argmax scheduler
module tb_stoch_argmax_sched;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, start4 = 1'b0;
  logic [3:0] a_p = '0, a_m = '0, a_p4 = '0, a_m4 = '0;
  logic       busy, done, winner_valid, y_p, y_m;
  logic       busy4, done4, winner_valid4, y_p4, y_m4;
  logic [1:0] winner_idx, winner_idx4;
  int         n_checks = 0, n_err = 0;
  int         exp_q[$];
  always #5 CLK = ~CLK;
  stoch_argmax_sched #(.N_IN(4), .WINDOW(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .a_p(a_p), .a_m(a_m), .busy(busy), .done(done),
    .winner_valid(winner_valid), .winner_idx(winner_idx), .y_p(y_p), .y_m(y_m));
  stoch_argmax_sched #(.N_IN(4), .WINDOW(16), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .start(start4), .a_p(a_p4), .a_m(a_m4), .busy(busy4), .done(done4),
    .winner_valid(winner_valid4), .winner_idx(winner_idx4), .y_p(y_p4), .y_m(y_m4));
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_search(input int exp_w, input bit repulse, input bit rnd, input string tag);
    int dones = 0;
    int got;
    logic [1:0] r;
    exp_q.push_back(exp_w);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      check({tag, "_done"}, {31'b0, done}, {31'b0, c == 52});
      check({tag, "_busy"}, {31'b0, busy}, {31'b0, c <= 51});
      check({tag, "_valid"}, {31'b0, winner_valid}, {31'b0, c >= 52});
      if (c == 18) check({tag, "_champ18"}, {30'b0, winner_idx}, exp_w);
      if (done) begin
        dones++;
        got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check({tag, "_winner"}, {30'b0, winner_idx}, got);
        check({tag, "_yp"}, {31'b0, y_p}, {31'b0, a_p[exp_w]});
        check({tag, "_ym"}, {31'b0, y_m}, {31'b0, a_m[exp_w]});
      end
      start = repulse && (c == 10 || c == 17 || c == 52);
      if (rnd) begin
        r = 2'($urandom_range(0, 3));
        a_p = {4{r[0]}};
        a_m = {4{r[1]}};
      end
      step();
    end
    start = 1'b0;
    check({tag, "_ndone"}, dones, 1);
  endtask
  initial begin
    int got;
    int dones;
    step();
    step();
    RST = 1'b0;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_valid", {31'b0, winner_valid}, 0);
    check("rst_idx", {30'b0, winner_idx}, 0);
    check("rst_busy4", {31'b0, busy4}, 0);
    // stream 1 at +1, stream 2 at -1, streams 0 and 3 at 0
    a_p = 4'b0010;
    a_m = 4'b0100;
    run_search(1, 1'b0, 1'b0, "basic");
    run_search(1, 1'b1, 1'b0, "repulse");
    a_p = 4'b0000;
    a_m = 4'b0000;
    run_search(0, 1'b0, 1'b1, "ties");
    // stream 3 both channels high, stream 0 both low, others at -1
    a_p = 4'b1000;
    a_m = 4'b1110;
    run_search(0, 1'b0, 1'b0, "decode0");
    // reset in cycle 20 of a search after a prior valid result
    a_p = 4'b0010;
    a_m = 4'b0100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_valid", {31'b0, winner_valid}, 0);
    check("midrst_idx", {30'b0, winner_idx}, 0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      dones += int'(done) + int'(busy);
      step();
    end
    check("midrst_quiet", dones, 0);
    run_search(1, 1'b0, 1'b0, "postrst");
    // narrow accumulator: 0 vs 1 saturates at +7
    a_p4 = 4'b0010;
    a_m4 = 4'b1101;
    exp_q.push_back(1);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    dones = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10 || c == 17) check("sat_acc", 32'(dut4.r_acc), 7);
      check("sat_done", {31'b0, done4}, {31'b0, c == 52});
      if (done4) begin
        dones++;
        got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check("sat_winner", {30'b0, winner_idx4}, got);
        check("sat_valid", {31'b0, winner_valid4}, 1);
      end
      step();
    end
    check("sat_ndone", dones, 1);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/stoch_argmax_sched.md
STOCH_ARGMAX_SCHED -- requirements
Module: stoch_argmax_sched

Interface
REQ-001 Parameter N_IN, default 4: number of signed-channel stochastic input streams; SHALL be at least 2.
REQ-002 Parameter WINDOW, default 16: number of bitstream samples per pairwise comparison; SHALL be at least 1.
REQ-003 Parameter CNT_W, default 8: width of the two's-complement comparison accumulator; SHALL be at least 3.
REQ-004 Derived IDX_W = max(1, clog2(N_IN)).
REQ-005 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request for a new argmax search; sampled only in IDLE.
REQ-008 a_p  input  N_IN  positive channel of each input stream; bit i belongs to stream i.
REQ-009 a_m  input  N_IN  negative channel of each input stream; bit i belongs to stream i.
REQ-010 busy  output  1  high while a search is in progress (RUN or DECIDE).
REQ-011 done  output  1  one-cycle pulse when a search completes.
REQ-012 winner_valid  output  1  winner_idx holds a completed result.
REQ-013 winner_idx  output  IDX_W  index of the current champion stream.
REQ-014 y_p, y_m  output  1 each  combinational forward of a_p[winner_idx] and a_m[winner_idx].

Function
REQ-015 The block SHALL decode a per-cycle sample value of each stream i:
  - v_i = +1 when a_p[i]=1 and a_m[i]=0;
  - v_i = -1 when a_m[i]=1 and a_p[i]=0;
  - v_i = 0 otherwise.
REQ-016 The FSM SHALL have the states IDLE, RUN, DECIDE and DONE.
REQ-017 IDLE with start=1 SHALL enter RUN and set champion=0, challenger=1, acc=0, sample count=0, winner_valid=0.
REQ-018 In RUN, each cycle SHALL add (v_challenger - v_champion), a value in -2..+2, to acc and increment the sample count.
REQ-019 RUN SHALL last exactly WINDOW cycles and then enter DECIDE.
REQ-020 acc SHALL saturate at -2^(CNT_W-1) and 2^(CNT_W-1)-1 and SHALL never wrap.
REQ-021 In DECIDE, champion SHALL take the challenger index when acc > 0; acc <= 0 (tie included) SHALL keep the champion.
REQ-022 DECIDE SHALL also clear acc and the sample count.
REQ-023 After DECIDE, the FSM SHALL enter DONE when challenger = N_IN-1; otherwise it SHALL increment challenger and re-enter RUN.
REQ-024 In DONE, done=1 and winner_valid=1 SHALL be asserted and the FSM SHALL enter IDLE on the next cycle.
REQ-025 winner_valid SHALL stay high until the next accepted start.
REQ-026 Latency: counting the cycle after the start edge as cycle 1, done SHALL be high in cycle (N_IN-1)*(WINDOW+1)+1.
REQ-027 start SHALL be ignored in RUN, DECIDE and DONE, with no queuing.
REQ-028 winner_idx SHALL equal the champion register at all times, including intermediate champions during a search.
REQ-029 y_p and y_m SHALL follow winner_idx with no added latency.

Reset
REQ-030 With RST=1 at a rising edge, the next cycle SHALL show: state IDLE, busy=0, done=0, winner_valid=0, winner_idx=0, acc=0, sample count=0, challenger=1.
REQ-031 Reset SHALL take priority over start and over any in-progress search.
REQ-032 A search interrupted by reset SHALL produce no done pulse.

Verification (N_IN=4, WINDOW=16, CNT_W=8 unless stated)
REQ-033 Stimulus: stream 1 held at +1 (p=1, m=0); streams 0 and 3 held at 0; stream 2 held at -1; start pulsed.
  - Required: done in cycle 52 only; winner_idx=1; winner_valid=1.
  - Required: y_p=a_p[1] and y_m=a_m[1] afterwards.
REQ-034 Stimulus: all four streams identical random bitstreams.
  - Required: winner_idx=0 at done (ties keep champion).
REQ-035 Stimulus: CNT_W=4; stream 0 at -1, stream 1 at +1, streams 2 and 3 at -1.
  - Required: acc clamps at +7 with no wrap to negative.
  - Required: winner_idx=1 at done.
REQ-036 Stimulus: start re-pulsed in cycles 10, 17 and 52 of a running search.
  - Required: exactly one done pulse, in cycle 52; the FSM returns to IDLE and waits for a fresh start.
REQ-037 Stimulus: RST=1 in cycle 20 of a search.
  - Required: busy=0, done=0, winner_valid=0 and winner_idx=0 in the next cycle.
  - Required: a subsequent start completes normally in 52 cycles.
REQ-038 Stimulus: stream 3 held at p=1, m=1 and stream 0 at p=0, m=0; all others at -1.
  - Required: both p=1,m=1 and p=0,m=0 decode as 0; winner_idx=0 at done (tie against stream 3).
